// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Redirect, instruction-memory and decode-side handshakes of the fetch stage.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic                   redirect_valid;
  logic [INSTR_WIDTH-1:0] redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [INSTR_WIDTH-1:0] imem_req_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [INSTR_WIDTH-1:0] inst_data;
  logic [INSTR_WIDTH-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched {pc, data} entries; head is read straight from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  // The credit check upstream must make a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && !clear && (count == CW'(DEPTH))));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, queues returned
// words for decode and flushes stale traffic on a redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [INSTR_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned            QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [INSTR_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0] pc_next;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          outstanding_next;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          drop_next;
  logic [CW-1:0]          q_count;

  logic                   redirect;
  logic                   resp;
  logic                   drop_active;
  logic                   req_valid_c;
  logic                   req_fire;
  logic                   push;
  logic                   pop;
  logic                   head_valid;
  logic [INSTR_WIDTH-1:0] redirect_aligned;
  fetch_entry_t           push_entry;
  fetch_entry_t           head;

  assign redirect         = bus.redirect_valid;
  assign resp             = bus.imem_resp_valid;
  assign drop_active      = (drop_cnt != '0);
  assign redirect_aligned = bus.redirect_pc & ~INSTR_WIDTH'(3);

  // In-flight reads plus buffered words may never exceed the queue size.
  assign req_valid_c = (state == S_FETCH) && !redirect &&
                       ((SW'(outstanding) + SW'(q_count)) < SW'(QUEUE_DEPTH));
  assign req_fire    = req_valid_c && bus.imem_req_ready;

  assign push = resp && !drop_active && !redirect;
  assign pop  = head_valid && bus.inst_ready && !redirect;

  // Oldest outstanding request sits 4 bytes behind the PC per in-flight read.
  assign push_entry = '{pc:   pc - (INSTR_WIDTH'(outstanding) << 2),
                        data: bus.imem_resp_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    outstanding_next = outstanding + CW'(req_fire) - CW'(resp);
    drop_next        = drop_cnt - CW'(resp && drop_active);

    case (state)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: state_next = S_FETCH;
      S_FLUSH: if (drop_next == '0) state_next = S_FETCH;
      default: state_next = S_BOOT;
    endcase

    if (req_fire) begin
      pc_next = pc + INSTR_WIDTH'(4);
    end

    // Everything still in flight, including a response landing now, is stale.
    if (redirect) begin
      pc_next          = redirect_aligned;
      outstanding_next = outstanding - CW'(resp);
      drop_next        = outstanding - CW'(resp);
      state_next       = (drop_next != '0) ? S_FLUSH : S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      pc          <= pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .clear      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .count      (q_count)
  );

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = head_valid;
  assign bus.inst_data      = head.data;
  assign bus.inst_pc        = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with random latency and
// a stream model of expected request addresses and delivered PCs.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int unsigned QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          c;
  } pend_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC    (RPC),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  pend_t       pend[$];
  logic [31:0] exp_req, exp_pc;
  int          live;
  int          req_mode, rdy_mode, resp_mode;
  bit          redir_arm, combo_arm, combo_hit;
  logic [31:0] redir_addr;
  bit          prev_hold, prev_redir;
  logic [31:0] prev_pc, prev_data;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    bit resp_now, redir_now, fire, popd;
    @(negedge clk);
    bus.imem_req_ready = pick(req_mode);
    bus.inst_ready     = pick(rdy_mode);
    resp_now = (pend.size() > 0) && (pend[0].c < cyc) &&
               ((resp_mode == 1) || ((resp_mode == 2) && ($urandom_range(0, 1) == 1)));
    bus.imem_resp_valid = resp_now;
    bus.imem_resp_data  = resp_now ? word(pend[0].addr) : $urandom;
    redir_now = redir_arm;
    if (combo_arm && bus.inst_valid && resp_now) begin
      redir_now      = 1'b1;
      bus.inst_ready = 1'b1;
      combo_arm      = 1'b0;
      combo_hit      = 1'b1;
    end
    bus.redirect_valid = redir_now;
    bus.redirect_pc    = redir_now ? redir_addr : $urandom;
    redir_arm = 1'b0;
    #1;
    if (prev_redir) begin
      chk("inst_valid_after_redirect", 32'(bus.inst_valid), 32'd0);
    end else if (prev_hold) begin
      chk("hold_valid", 32'(bus.inst_valid), 32'd1);
      chk("hold_pc", bus.inst_pc, prev_pc);
      chk("hold_data", bus.inst_data, prev_data);
    end
    if (redir_now) chk("req_valid_in_redirect", 32'(bus.imem_req_valid), 32'd0);
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req);
    fire = bus.imem_req_valid && bus.imem_req_ready;
    popd = bus.inst_valid && bus.inst_ready && !redir_now;
    if (popd) begin
      chk("inst_pc", bus.inst_pc, exp_pc);
      chk("inst_data", bus.inst_data, word(exp_pc));
      exp_pc += 32'd4;
      live--;
    end
    if (fire) begin
      pend.push_back('{addr: bus.imem_req_addr, c: cyc});
      exp_req += 32'd4;
      live++;
    end
    chk("credit", 32'(live <= int'(QD)), 32'd1);
    if (resp_now) void'(pend.pop_front());
    if (redir_now) begin
      exp_req = redir_addr & ~32'd3;
      exp_pc  = exp_req;
      live    = 0;
    end
    prev_redir = redir_now;
    prev_hold  = bus.inst_valid && !bus.inst_ready;
    prev_pc    = bus.inst_pc;
    prev_data  = bus.inst_data;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n             = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    bus.inst_ready      = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    pend.delete();
    exp_req    = RPC;
    exp_pc     = RPC;
    live       = 0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inst_valid_held", 32'(bus.inst_valid), 32'd0);
    bus.imem_resp_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("boot_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RPC);
    chk("first_inst_valid", 32'(bus.inst_valid), 32'd0);
  endtask

  initial begin
    reset_n             = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_ready      = 1'b0;
    redir_arm = 1'b0;
    combo_arm = 1'b0;
    combo_hit = 1'b0;
    redir_addr = 32'h0;

    do_reset();

    // Streaming at full rate, latency 1.
    req_mode = 1; rdy_mode = 1; resp_mode = 1;
    run(20);

    // Decode stalls: queue fills, requests stop, head held.
    rdy_mode = 0;
    run(10);
    chk("full_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    rdy_mode = 1;
    run(10);

    // Redirect with two requests outstanding.
    resp_mode = 0;
    run(6);
    chk("blocked_req_valid", 32'(bus.imem_req_valid), 32'd0);
    redir_arm = 1'b1; redir_addr = 32'h0000_1003;
    tick();
    resp_mode = 1;
    run(15);

    // PC wrap past the top of the address space.
    redir_arm = 1'b1; redir_addr = 32'hFFFF_FFF6;
    tick();
    run(20);

    // Redirect coinciding with a response and a decode pop.
    req_mode = 2; rdy_mode = 2; resp_mode = 2;
    combo_arm = 1'b1; combo_hit = 1'b0; redir_addr = 32'h0000_2000;
    for (int i = 0; i < 300 && combo_arm; i++) tick();
    chk("combo_reached", 32'(combo_hit), 32'd1);
    combo_arm = 1'b0;
    run(15);

    // Reset pulsed while stale responses are still being flushed.
    req_mode = 1; rdy_mode = 1; resp_mode = 0;
    run(4);
    redir_arm = 1'b1; redir_addr = 32'h0000_3000;
    tick();
    tick();
    do_reset();
    resp_mode = 1;
    run(15);

    // Random traffic with occasional redirects.
    req_mode = 2; rdy_mode = 2; resp_mode = 2;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        redir_arm  = 1'b1;
        redir_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Keeps the program counter and issues word-aligned read requests to instruction memory over a valid/ready handshake. Buffers returned words, each with its PC, in a small in-order queue and presents them to decode over a valid/ready handshake. A redirect from the branch/jump resolution logic flushes all in-flight and buffered instructions and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 2: fetch-queue entries and maximum outstanding+buffered instructions; a power of two, ≥2.

- clk  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  flush and restart at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] are forced to 0.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  request address, equal to the PC register.
- imem_resp_valid  input  1  read data valid; responses return in order, ≥1 cycle after acceptance, with no backpressure.
- imem_resp_data  input  32  instruction word.
- inst_valid  output  1  queue head valid toward decode.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  32  instruction word; feeds the decoder instruction input.
- inst_pc  output  32  PC of inst_data.

## Operation
- FSM states:
  - S_BOOT: one cycle after reset release; no requests; goes to S_FETCH.
  - S_FETCH: normal operation.
  - S_FLUSH: discards stale responses; goes to S_FETCH when drop_cnt reaches 0.
- Credit rule: imem_req_valid = (state==S_FETCH) && !redirect_valid && (outstanding + queue_count < QUEUE_DEPTH). A pop in the same cycle is not counted (conservative).
- Request handshake (valid && ready): PC <= PC+4, wrapping 32'hFFFF_FFFC -> 0; outstanding increments.
- Response: outstanding decrements.
  - If drop_cnt==0: push {PC of the oldest outstanding request, data} into the queue. A queue of outstanding request PCs, or PC minus 4×in-flight, tracks that PC.
  - If drop_cnt>0: discard the response; drop_cnt decrements.
- Pop when inst_valid && inst_ready. A simultaneous push and pop keeps the count unchanged. Overflow is impossible by the credit rule; it is asserted in simulation.
- Redirect has priority over everything in its cycle:
  - Queue cleared; PC <= {redirect_pc[31:2],2'b00}; no request issued.
  - drop_cnt <= outstanding − imem_resp_valid (a response arriving in the redirect cycle is also discarded).
  - Next state: S_FLUSH if drop_cnt is nonzero, else S_FETCH.
  - A redirect during S_FLUSH or S_BOOT is handled identically, with drop_cnt recomputed.
- Counter widths: outstanding and drop_cnt are $clog2(QUEUE_DEPTH)+1 bits.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - Counters 0, state S_BOOT.
- First request is visible 1 cycle after reset_n rises.
- Latency from imem_resp_valid to inst_valid (empty queue) is 1 cycle; the queue is registered, with no bypass.
- Latency from redirect_valid to imem_req_valid for the new PC is 1 cycle when nothing is outstanding. Otherwise it is 1 cycle after the last stale response.
- inst_valid falls the cycle after a redirect.
- inst_data and inst_pc hold stable while inst_valid && !inst_ready.
- imem_req_addr is stable while imem_req_valid && !imem_req_ready.
- Reset asserted mid-operation: outputs return to reset values immediately; any response arriving while in reset is ignored.

## Structure
- Shared package (fetch_pkg):
  - FSM state typedef (S_BOOT, S_FETCH, S_FLUSH).
  - INSTR_WIDTH=32.
  - Default RESET_PC.
  - Queue-entry struct {pc, data}.
- Sub-module fetch_queue: synchronous FIFO of QUEUE_DEPTH entries with push, pop, clear, count, and head outputs; async active-low reset.

## Test plan
- Reset release, imem_req_ready=1, memory latency 1 -> requests to 0x0, 0x4, 0x8…; inst_pc/inst_data emerge in order, at most 2 outstanding+buffered.
- inst_ready=0 for 10 cycles -> queue fills at 2 entries; imem_req_valid drops; head held stable; resumes exactly without loss or duplication.
- Redirect to 0x1003 with 2 requests outstanding -> next request address 0x1000; both stale responses dropped; first delivered inst_pc=0x1000.
- Redirect in the same cycle as a response and a decode pop -> response discarded; inst_valid=0 next cycle; no queue corruption.
- PC at 0xFFFF_FFFC -> next request 0x0000_0000.
- reset_n pulsed low mid-flush -> all outputs at reset values; fetch restarts at RESET_PC with drop_cnt=0.
